// File: rtl/adma_engine.sv
// adma_engine
//   Simplified ADMA transfer sequencer. It walks a system address across a
//   number of fixed-size blocks. It publishes each block's start address and
//   reports 4 KiB page crossings, completion and parameter errors over
//   valid/ack handshakes.
//
// Ports
//   clk, reset                    clock, asynchronous active-high reset
//   Initial_ADMA_System_Address   start address, captured when a transfer starts
//   Block_Size_Register           [11:0] block size in bytes
//   Block_Count_Register          block count (used when multi-block + count enable)
//   Transfer_Mode_Register        [0] DMA enable, [1] block count enable, [5] multi-block
//   Present_State_Register        [1] DAT inhibit
//   Block_Gap_Control_Register    [0] stop at gap, [1] continue
//   Command_Register              [5] data present
//   DMA_Interrupt / enb_ / ack_   page-crossing event handshake
//   ADMA_Error / enb_ / ack_      parameter error handshake
//   Transfer_complete / enb_ / ack_  completion handshake
//   ADMA_System_Address_Register / enb_ / ack_  current block address handshake
module adma_engine (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] Initial_ADMA_System_Address,
  input  logic [15:0] Block_Size_Register,
  input  logic [15:0] Block_Count_Register,
  input  logic [15:0] Transfer_Mode_Register,
  input  logic [31:0] Present_State_Register,
  input  logic [7:0]  Block_Gap_Control_Register,
  input  logic [15:0] Command_Register,
  output logic        DMA_Interrupt,
  output logic        ADMA_Error,
  output logic        Transfer_complete,
  output logic [63:0] ADMA_System_Address_Register,
  output logic        enb_DMA_Interrupt,
  input  logic        ack_DMA_Interrupt,
  output logic        enb_ADMA_Error,
  input  logic        ack_ADMA_Error,
  output logic        enb_Transfer_complete,
  input  logic        ack_Transfer_complete,
  output logic        enb_ADMA_System_Address_Register,
  input  logic        ack_ADMA_System_Address_Register
);

  typedef enum logic [2:0] {
    S_STOP, S_FDS, S_CADR, S_TFR, S_INT, S_GAP, S_DONE, S_ERR
  } state_t;

  state_t      r_state;
  logic [63:0] r_addr;
  logic [15:0] r_cnt;

  logic        w_dma_en;
  logic        w_start;
  logic [11:0] w_bsize;
  logic [63:0] w_next_addr;
  logic        w_cross;
  logic        w_param_err;
  logic [15:0] w_cnt_init;
  logic        w_unused;

  assign w_dma_en    = Transfer_Mode_Register[0];
  assign w_start     = Transfer_Mode_Register[0] & Command_Register[5] & ~Present_State_Register[1];
  assign w_bsize     = Block_Size_Register[11:0];
  assign w_next_addr = r_addr + {52'd0, w_bsize};
  assign w_cross     = (w_next_addr[63:12] != r_addr[63:12]);
  assign w_param_err = (w_bsize == 12'd0) ||
                       (Transfer_Mode_Register[1] && Transfer_Mode_Register[5] &&
                        (Block_Count_Register == 16'd0));
  // Multi-block without a count enable runs for the maximum count.
  assign w_cnt_init  = !Transfer_Mode_Register[5] ? 16'd1 :
                       (Transfer_Mode_Register[1] ? Block_Count_Register : '1);

  assign w_unused = ^{Block_Size_Register[15:12], Transfer_Mode_Register[15:6],
                      Transfer_Mode_Register[4:2], Present_State_Register[31:2],
                      Present_State_Register[0], Block_Gap_Control_Register[7:2],
                      Command_Register[15:6], Command_Register[4:0]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state                          <= S_STOP;
      r_addr                           <= '0;
      r_cnt                            <= '0;
      DMA_Interrupt                    <= 1'b0;
      ADMA_Error                       <= 1'b0;
      Transfer_complete                <= 1'b0;
      ADMA_System_Address_Register     <= '0;
      enb_DMA_Interrupt                <= 1'b0;
      enb_ADMA_Error                   <= 1'b0;
      enb_Transfer_complete            <= 1'b0;
      enb_ADMA_System_Address_Register <= 1'b0;
    end else if ((r_state != S_STOP) && !w_dma_en) begin
      // Abort outranks every other transition and clears every output.
      r_state                          <= S_STOP;
      DMA_Interrupt                    <= 1'b0;
      ADMA_Error                       <= 1'b0;
      Transfer_complete                <= 1'b0;
      ADMA_System_Address_Register     <= '0;
      enb_DMA_Interrupt                <= 1'b0;
      enb_ADMA_Error                   <= 1'b0;
      enb_Transfer_complete            <= 1'b0;
      enb_ADMA_System_Address_Register <= 1'b0;
    end else begin
      case (r_state)
        S_STOP: begin
          if (w_start) begin
            r_addr  <= Initial_ADMA_System_Address;
            r_cnt   <= w_cnt_init;
            r_state <= S_FDS;
          end
        end
        S_FDS: begin
          if (w_param_err) begin
            ADMA_Error     <= 1'b1;
            enb_ADMA_Error <= 1'b1;
            r_state        <= S_ERR;
          end else begin
            ADMA_System_Address_Register     <= r_addr;
            enb_ADMA_System_Address_Register <= 1'b1;
            r_state                          <= S_CADR;
          end
        end
        S_CADR: begin
          if (ack_ADMA_System_Address_Register) begin
            enb_ADMA_System_Address_Register <= 1'b0;
            r_state                          <= S_TFR;
          end
        end
        S_TFR: begin
          r_addr <= w_next_addr;
          r_cnt  <= r_cnt - 16'd1;
          if (w_cross) begin
            DMA_Interrupt     <= 1'b1;
            enb_DMA_Interrupt <= 1'b1;
            r_state           <= S_INT;
          end else if (r_cnt == 16'd1) begin
            Transfer_complete     <= 1'b1;
            enb_Transfer_complete <= 1'b1;
            r_state               <= S_DONE;
          end else if (Block_Gap_Control_Register[0]) begin
            r_state <= S_GAP;
          end else begin
            ADMA_System_Address_Register     <= w_next_addr;
            enb_ADMA_System_Address_Register <= 1'b1;
            r_state                          <= S_CADR;
          end
        end
        S_INT: begin
          // r_cnt was already decremented in TFR, so zero here means the
          // block just finished was the last one.
          if (ack_DMA_Interrupt) begin
            DMA_Interrupt     <= 1'b0;
            enb_DMA_Interrupt <= 1'b0;
            if (r_cnt == 16'd0) begin
              Transfer_complete     <= 1'b1;
              enb_Transfer_complete <= 1'b1;
              r_state               <= S_DONE;
            end else if (Block_Gap_Control_Register[0]) begin
              r_state <= S_GAP;
            end else begin
              ADMA_System_Address_Register     <= r_addr;
              enb_ADMA_System_Address_Register <= 1'b1;
              r_state                          <= S_CADR;
            end
          end
        end
        S_GAP: begin
          if (Block_Gap_Control_Register[1]) begin
            ADMA_System_Address_Register     <= r_addr;
            enb_ADMA_System_Address_Register <= 1'b1;
            r_state                          <= S_CADR;
          end
        end
        S_DONE: begin
          if (ack_Transfer_complete) begin
            Transfer_complete     <= 1'b0;
            enb_Transfer_complete <= 1'b0;
            r_state               <= S_STOP;
          end
        end
        S_ERR: begin
          if (ack_ADMA_Error) begin
            ADMA_Error     <= 1'b0;
            enb_ADMA_Error <= 1'b0;
            r_state        <= S_STOP;
          end
        end
        default: r_state <= S_STOP;
      endcase
    end
  end

endmodule

// File: tb/tb_adma_engine.sv
module tb_adma_engine;

  localparam int K_ADDR = 0;
  localparam int K_INT  = 1;
  localparam int K_DONE = 2;
  localparam int K_ERR  = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [63:0] init_addr = '0;
  logic [15:0] bs_reg = '0;
  logic [15:0] bc_reg = '0;
  logic [15:0] tm_reg = '0;
  logic [31:0] ps_reg = '0;
  logic [7:0]  bgc_reg = '0;
  logic [15:0] cmd_reg = '0;
  logic        dma_int, adma_err, xfer_done;
  logic [63:0] addr_reg;
  logic        enb_int, enb_err, enb_done, enb_addr;
  logic [3:0]  acks = '0;   // {addr, done, err, int}
  logic [3:0]  w_enb;

  assign w_enb = {enb_addr, enb_done, enb_err, enb_int};

  always #5 clk = ~clk;

  adma_engine dut (
    .clk                              (clk),
    .reset                            (reset),
    .Initial_ADMA_System_Address      (init_addr),
    .Block_Size_Register              (bs_reg),
    .Block_Count_Register             (bc_reg),
    .Transfer_Mode_Register           (tm_reg),
    .Present_State_Register           (ps_reg),
    .Block_Gap_Control_Register       (bgc_reg),
    .Command_Register                 (cmd_reg),
    .DMA_Interrupt                    (dma_int),
    .ADMA_Error                       (adma_err),
    .Transfer_complete                (xfer_done),
    .ADMA_System_Address_Register     (addr_reg),
    .enb_DMA_Interrupt                (enb_int),
    .ack_DMA_Interrupt                (acks[0]),
    .enb_ADMA_Error                   (enb_err),
    .ack_ADMA_Error                   (acks[1]),
    .enb_Transfer_complete            (enb_done),
    .ack_Transfer_complete            (acks[2]),
    .enb_ADMA_System_Address_Register (enb_addr),
    .ack_ADMA_System_Address_Register (acks[3])
  );

  int tests = 0;
  int fails = 0;
  int ack_delay = 2;
  int hold [4] = '{0, 0, 0, 0};
  int          ob_kind[$];
  logic [63:0] ob_val[$];
  int          m_kind[$];
  logic [63:0] m_val[$];
  logic [3:0]  prev_enb = '0;
  logic [63:0] prev_addr_reg = '0;
  int          cur_len = 0;
  int          last_addr_len = 0;

  // Event monitor, invariant checks and ack responder.
  always @(negedge clk) begin
    if (!reset) begin
      tests++;
      if ($countones(w_enb) > 1) begin
        fails++;
        $display("FAIL onehot_enb: got enb=%b, required at most one high", w_enb);
      end
      tests++;
      if ({dma_int, adma_err, xfer_done} !== {enb_int, enb_err, enb_done}) begin
        fails++;
        $display("FAIL flag_vs_enb: got flags=%b, required equal to enb=%b",
                 {dma_int, adma_err, xfer_done}, {enb_int, enb_err, enb_done});
      end
      if (enb_addr && prev_enb[3]) begin
        tests++;
        if (addr_reg !== prev_addr_reg) begin
          fails++;
          $display("FAIL addr_stable: got %h, required %h", addr_reg, prev_addr_reg);
        end
      end
      if (enb_addr && !prev_enb[3]) begin ob_kind.push_back(K_ADDR); ob_val.push_back(addr_reg); end
      if (enb_int  && !prev_enb[0]) begin ob_kind.push_back(K_INT);  ob_val.push_back('0); end
      if (enb_done && !prev_enb[2]) begin ob_kind.push_back(K_DONE); ob_val.push_back('0); end
      if (enb_err  && !prev_enb[1]) begin ob_kind.push_back(K_ERR);  ob_val.push_back('0); end
      if (enb_addr) cur_len++;
      else if (prev_enb[3]) begin last_addr_len = cur_len; cur_len = 0; end
    end
    prev_enb      = w_enb;
    prev_addr_reg = addr_reg;
    for (int i = 0; i < 4; i++) begin
      if (acks[i]) begin
        acks[i] = 1'b0;
        hold[i] = 0;
      end else if (w_enb[i]) begin
        hold[i]++;
        if (hold[i] >= ack_delay) acks[i] = 1'b1;
      end else begin
        hold[i] = 0;
      end
    end
  end

  // Expected handshake sequence from the transfer rules, truncated to max_ev.
  task automatic model(input logic [63:0] a0, input logic [15:0] bs, input logic [15:0] bc,
                       input logic [15:0] tm, input int max_ev);
    int unsigned nblk;
    logic [63:0] a;
    logic [63:0] na;
    logic [63:0] sz;
    m_kind.delete();
    m_val.delete();
    sz = {52'd0, bs[11:0]};
    if (!tm[5])     nblk = 1;
    else if (tm[1]) nblk = 32'(bc);
    else            nblk = 65535;
    if (sz == 64'd0 || (tm[5] && tm[1] && bc == 16'd0)) begin
      m_kind.push_back(K_ERR);
      m_val.push_back('0);
    end else begin
      a = a0;
      for (int unsigned i = 0; i < nblk && m_kind.size() < max_ev; i++) begin
        m_kind.push_back(K_ADDR);
        m_val.push_back(a);
        na = a + sz;
        if ((na >> 12) != (a >> 12)) begin
          m_kind.push_back(K_INT);
          m_val.push_back('0);
        end
        a = na;
      end
      if (m_kind.size() < max_ev) begin
        m_kind.push_back(K_DONE);
        m_val.push_back('0);
      end
    end
  endtask

  task automatic start_xfer(input logic [63:0] a, input logic [15:0] bs, input logic [15:0] bc,
                            input logic [15:0] tm, input logic [7:0] bgc);
    @(negedge clk);
    ob_kind.delete();
    ob_val.delete();
    init_addr = a; bs_reg = bs; bc_reg = bc; tm_reg = tm; bgc_reg = bgc;
    cmd_reg = 16'h0020;
    @(negedge clk);
    cmd_reg = 16'h0000;
  endtask

  task automatic wait_end(input string nm, input int bound);
    bit seen = 1'b0;
    for (int i = 0; i < bound && !seen; i++) begin
      @(negedge clk);
      if (ob_kind.size() > 0 && (ob_kind[$] == K_DONE || ob_kind[$] == K_ERR) && w_enb == 4'b0)
        seen = 1'b1;
    end
    tests++;
    if (!seen) begin
      fails++;
      $display("FAIL %s timeout: got no terminal handshake, required one within %0d cycles", nm, bound);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    #1 reset = 1'b1;
    #1;
    tests++;
    if ({dma_int, adma_err, xfer_done, w_enb, addr_reg} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got enb=%b addr=%h, required all zero", w_enb, addr_reg);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_directed();
    logic [63:0] ta  [4] = '{64'h1000, 64'h1000, 64'h1000, 64'hFFFF_FFFF_FFFF_FF00};
    logic [15:0] tbs [4] = '{16'h0200, 16'h0800, 16'h0000, 16'h0200};
    logic [15:0] tbc [4] = '{16'd0, 16'd3, 16'd1, 16'd2};
    logic [15:0] ttm [4] = '{16'h0001, 16'h0023, 16'h0001, 16'h0023};
    string       tnm [4] = '{"single", "boundary", "param_error", "wrap"};
    for (int t = 0; t < 4; t++) begin
      ack_delay = 2;
      model(ta[t], tbs[t], tbc[t], ttm[t], 1000);
      start_xfer(ta[t], tbs[t], tbc[t], ttm[t], 8'h00);
      wait_end(tnm[t], 500);
      tests++;
      if (ob_kind.size() != m_kind.size()) begin
        fails++;
        $display("FAIL %s event_count: got %0d, required %0d", tnm[t], ob_kind.size(), m_kind.size());
      end
      for (int i = 0; i < m_kind.size() && i < ob_kind.size(); i++) begin
        tests++;
        if (ob_kind[i] !== m_kind[i] || ob_val[i] !== m_val[i]) begin
          fails++;
          $display("FAIL %s event%0d: got kind %0d val %h, required kind %0d val %h",
                   tnm[t], i, ob_kind[i], ob_val[i], m_kind[i], m_val[i]);
        end
      end
      for (int i = m_kind.size() - 1; i >= 0; i--) begin
        if (m_kind[i] == K_ADDR) begin
          tests++;
          if (addr_reg !== m_val[i]) begin
            fails++;
            $display("FAIL %s final_addr: got %h, required %h", tnm[t], addr_reg, m_val[i]);
          end
          break;
        end
      end
    end
  endtask

  task automatic test_gap();
    bit got = 1'b0;
    ack_delay = 2;
    model(64'h1000, 16'h0200, 16'd2, 16'h0023, 1000);
    start_xfer(64'h1000, 16'h0200, 16'd2, 16'h0023, 8'h01);
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if (ob_kind.size() >= 1) got = 1'b1;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      tests++;
      if (w_enb !== 4'b0) begin
        fails++;
        $display("FAIL gap_parked: got enb=%b, required 0000", w_enb);
      end
    end
    tests++;
    if (ob_kind.size() != 1) begin
      fails++;
      $display("FAIL gap_events_before_continue: got %0d, required 1", ob_kind.size());
    end
    bgc_reg = 8'h02;
    wait_end("gap", 500);
    bgc_reg = 8'h00;
    tests++;
    if (ob_kind.size() != m_kind.size()) begin
      fails++;
      $display("FAIL gap event_count: got %0d, required %0d", ob_kind.size(), m_kind.size());
    end
    for (int i = 0; i < m_kind.size() && i < ob_kind.size(); i++) begin
      tests++;
      if (ob_kind[i] !== m_kind[i] || ob_val[i] !== m_val[i]) begin
        fails++;
        $display("FAIL gap event%0d: got kind %0d val %h, required kind %0d val %h",
                 i, ob_kind[i], ob_val[i], m_kind[i], m_val[i]);
      end
    end
  endtask

  task automatic test_ack_holdoff();
    ack_delay = 6;
    model(64'h5000, 16'h0100, 16'd2, 16'h0023, 1000);
    start_xfer(64'h5000, 16'h0100, 16'd2, 16'h0023, 8'h00);
    wait_end("holdoff", 500);
    tests++;
    if (last_addr_len != 6) begin
      fails++;
      $display("FAIL holdoff_enb_len: got %0d cycles, required 6", last_addr_len);
    end
    tests++;
    if (ob_kind.size() != m_kind.size()) begin
      fails++;
      $display("FAIL holdoff event_count: got %0d, required %0d", ob_kind.size(), m_kind.size());
    end
    for (int i = 0; i < m_kind.size() && i < ob_kind.size(); i++) begin
      tests++;
      if (ob_kind[i] !== m_kind[i] || ob_val[i] !== m_val[i]) begin
        fails++;
        $display("FAIL holdoff event%0d: got kind %0d val %h, required kind %0d val %h",
                 i, ob_kind[i], ob_val[i], m_kind[i], m_val[i]);
      end
    end
    ack_delay = 2;
  endtask

  task automatic test_abort();
    bit got = 1'b0;
    ack_delay = 1000;
    start_xfer(64'h1000, 16'h0200, 16'd4, 16'h0023, 8'h00);
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (enb_addr) got = 1'b1;
    end
    tests++;
    if (!got) begin
      fails++;
      $display("FAIL abort_setup: got no address enb, required one");
    end
    @(negedge clk);
    tm_reg = 16'h0022;
    @(negedge clk);
    tests++;
    if ({dma_int, adma_err, xfer_done, w_enb, addr_reg} !== '0) begin
      fails++;
      $display("FAIL abort_outputs: got enb=%b addr=%h, required all zero", w_enb, addr_reg);
    end
    ack_delay = 2;
    repeat (20) @(negedge clk);
    tests++;
    if (ob_kind.size() != 1) begin
      fails++;
      $display("FAIL abort_no_more_events: got %0d events, required 1", ob_kind.size());
    end
    tm_reg = 16'h0001;
  endtask

  task automatic test_reset_mid();
    bit got = 1'b0;
    ack_delay = 2;
    start_xfer(64'h1000, 16'h0200, 16'd3, 16'h0023, 8'h00);
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (acks[3]) got = 1'b1;
    end
    tests++;
    if (!got) begin
      fails++;
      $display("FAIL reset_mid_setup: got no address ack, required one");
    end
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    tests++;
    if ({dma_int, adma_err, xfer_done, w_enb, addr_reg} !== '0) begin
      fails++;
      $display("FAIL reset_mid_outputs: got enb=%b addr=%h, required all zero", w_enb, addr_reg);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    ob_kind.delete();
    ob_val.delete();
    repeat (20) @(negedge clk);
    tests++;
    if (ob_kind.size() != 0) begin
      fails++;
      $display("FAIL reset_mid_no_events: got %0d events, required 0", ob_kind.size());
    end
  endtask

  task automatic test_unbounded_count();
    bit got = 1'b0;
    ack_delay = 1;
    model(64'h3000, 16'h0400, 16'd3, 16'h0021, 6);
    start_xfer(64'h3000, 16'h0400, 16'd3, 16'h0021, 8'h00);
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge clk);
      if (ob_kind.size() >= 6) got = 1'b1;
    end
    tm_reg = 16'h0020;
    repeat (3) @(negedge clk);
    tests++;
    if (ob_kind.size() != m_kind.size()) begin
      fails++;
      $display("FAIL unbounded event_count: got %0d, required %0d", ob_kind.size(), m_kind.size());
    end
    for (int i = 0; i < m_kind.size() && i < ob_kind.size(); i++) begin
      tests++;
      if (ob_kind[i] !== m_kind[i] || ob_val[i] !== m_val[i]) begin
        fails++;
        $display("FAIL unbounded event%0d: got kind %0d val %h, required kind %0d val %h",
                 i, ob_kind[i], ob_val[i], m_kind[i], m_val[i]);
      end
    end
    tm_reg = 16'h0001;
    ack_delay = 2;
  endtask

  task automatic test_random();
    logic [15:0] tms [3] = '{16'h0001, 16'h0023, 16'h0003};
    logic [63:0] a;
    logic [15:0] bs, bc, tm;
    string       nm;
    for (int n = 0; n < 12; n++) begin
      a  = {$urandom, $urandom};
      bs = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom_range(1, 4095));
      bc = 16'($urandom_range(0, 4));
      tm = tms[$urandom_range(0, 2)];
      ack_delay = int'($urandom_range(1, 3));
      nm = $sformatf("random%0d", n);
      model(a, bs, bc, tm, 1000);
      start_xfer(a, bs, bc, tm, 8'h00);
      wait_end(nm, 1000);
      tests++;
      if (ob_kind.size() != m_kind.size()) begin
        fails++;
        $display("FAIL %s event_count: got %0d, required %0d", nm, ob_kind.size(), m_kind.size());
      end
      for (int i = 0; i < m_kind.size() && i < ob_kind.size(); i++) begin
        tests++;
        if (ob_kind[i] !== m_kind[i] || ob_val[i] !== m_val[i]) begin
          fails++;
          $display("FAIL %s event%0d: got kind %0d val %h, required kind %0d val %h",
                   nm, i, ob_kind[i], ob_val[i], m_kind[i], m_val[i]);
        end
      end
    end
    ack_delay = 2;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_gap();
    test_ack_holdoff();
    test_abort();
    test_reset_mid();
    test_unbounded_count();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
